if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised instruction buffer replacing the single-entry IF→ID pipeline register of the MIPS core. It holds up to DEPTH fetched instructions, each with its PC, exception bits and delay-slot flag, so fetch and decode are decoupled by a valid/ready handshake rather than a global stall. It derives the PC+4, PC+8 and PC−4 views at the output instead of storing them. A single flush empties it in one cycle.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- INST_W, 32: instruction width.
- ADDR_W, 32: PC width.
- EXC_W, 8: exception-code bus width.
- AF_LEVEL, DEPTH-1: occupancy at or above which almost_full_ asserts; 1..DEPTH.

Ports:
- _clk  in  1  clock; all state on rising edge.
- _rst  in  1  reset, asynchronous, active-low.
- _flush  in  1  discard all entries and drop this cycle's push/pop.
- _valid  in  1  IF presents an entry.
- ready_  out  1  queue accepts an entry this cycle.
- _inst  in  INST_W  fetched instruction.
- _pc  in  ADDR_W  PC of the instruction.
- _exc  in  EXC_W  fetch exception code (0 = none).
- _jb_delaysolt  in  1  entry is a branch/jump delay slot.
- valid_  out  1  head entry available to ID.
- _ready  in  1  ID consumes the head this cycle.
- inst_  out  INST_W  head instruction.
- pc_  out  ADDR_W  head PC.
- pc_add4_, pc_add8_, pc_sub4_  out  ADDR_W  head PC +4, +8, −4.
- exc_  out  EXC_W  head exception code.
- jb_delaysolt_  out  1  head delay-slot flag.
- count_  out  $clog2(DEPTH)+1  current occupancy.
- almost_full_  out  1  count_ ≥ AF_LEVEL.

## Operation
- Storage: circular buffer of DEPTH entries {inst, pc, exc, ds}. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH. count_ is a separate register.
- push = _valid & ready_ & ~_flush. pop = valid_ & _ready & ~_flush.
- ready_ = (count_ != DEPTH). Combinational from the count register only, with no dependency on _ready. A full queue therefore refuses a push even when a pop occurs in the same cycle.
- valid_ = (count_ != 0).
- Head outputs are read combinationally from the entry at the read pointer, gated by valid_.
  - When empty: inst_=0 (NOP), pc_=0, exc_=0, jb_delaysolt_=0.
  - The derived PC outputs are then 4, 8 and 2^ADDR_W−4.
- PC arithmetic is modulo 2^ADDR_W: pc_add4_=pc_+4, pc_add8_=pc_+8, pc_sub4_=pc_−4, with no overflow flag.
- Push writes the entry at the write pointer, then increments the pointer. Pop increments the read pointer.
- Count update: push & ~pop → +1; pop & ~push → −1; both or neither → unchanged.
- Push and pop in the same cycle are legal whenever 0 < count_ < DEPTH. When count_ = 0, pop is impossible, so the push alone takes effect.
- Flush takes priority over everything. Next cycle: count_=0 and read pointer = write pointer = 0. Stored data is not cleared.
- Entries carrying a nonzero _exc are queued and delivered like any other entry; the queue never interprets them.
- almost_full_ is combinational from the count register.

## Timing
- Reset (async assert, _rst=0): count_=0, both pointers 0. Outputs: valid_=0, ready_=1, almost_full_=0, head outputs at their empty values. Release is synchronous to _clk via the usual reset synchroniser upstream.
- Latency: an entry pushed at edge N is visible at the head (valid_=1) after edge N. There is no same-cycle bypass, so the minimum IF→ID latency is one cycle, matching the old register.
- Throughput: one push and one pop per cycle sustained while not full.
- Flush at edge N: valid_=0 and ready_=1 after edge N. Any entry presented to IF at edge N is lost, and no pop is reported to ID.
- Reset mid-operation: contents are abandoned and all outputs return immediately to their reset values.
- Inputs must be stable around the rising edge. _valid may drop without acceptance (no hold requirement on IF).

## Test plan
- Reset then idle → valid_=0, ready_=1, count_=0, inst_=0, pc_add4_=0x4, pc_sub4_=0xFFFFFFFC.
- Push pc=0xBFC00000, inst=0x24080001 with _ready=0 → next cycle valid_=1, pc_=0xBFC00000, pc_add8_=0xBFC00008, pc_sub4_=0xBFBFFFFC, count_=1.
- Push 4 entries (DEPTH=4) with _ready=0 → count_=4, ready_=0, almost_full_ asserted from count_=3. A fifth push with _ready=1 in the same cycle is refused: count_ goes to 3 and the fifth entry is not stored.
- Fill to 2, then 10 cycles of simultaneous push+pop with incrementing PCs across a pointer wrap → count_ stays 2, pops return PCs in exact push order, ds/exc bits follow their entries.
- Fill to 3, assert _flush together with _valid and _ready → next cycle count_=0, valid_=0, ready_=1. Then push pc=0x80000180 → it is the head after one cycle.
- Assert _rst with 2 entries queued, mid-cycle → valid_=0 and count_=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: circular instruction buffer between fetch (IF) and decode (ID).
// Each entry holds the instruction, its PC, the fetch exception code and the
// delay-slot flag. The head is presented combinationally from the read
// pointer, and the PC+4 / PC+8 / PC-4 views are derived from it rather than
// stored. A flush returns both pointers and the count to zero in one cycle.
module if_id_queue #(
    parameter int DEPTH    = 4,
    parameter int INST_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int EXC_W    = 8,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                   _clk,
    input  logic                   _rst,
    input  logic                   _flush,
    // IF side
    input  logic                   _valid,
    output logic                   ready_,
    input  logic [INST_W-1:0]      _inst,
    input  logic [ADDR_W-1:0]      _pc,
    input  logic [EXC_W-1:0]       _exc,
    input  logic                   _jb_delaysolt,
    // ID side
    output logic                   valid_,
    input  logic                   _ready,
    output logic [INST_W-1:0]      inst_,
    output logic [ADDR_W-1:0]      pc_,
    output logic [ADDR_W-1:0]      pc_add4_,
    output logic [ADDR_W-1:0]      pc_add8_,
    output logic [ADDR_W-1:0]      pc_sub4_,
    output logic [EXC_W-1:0]       exc_,
    output logic                   jb_delaysolt_,
    // status
    output logic [$clog2(DEPTH):0] count_,
    output logic                   almost_full_
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage; deliberately not reset, since occupancy is tracked by count
    logic [INST_W-1:0] mem_inst_r [DEPTH];
    logic [ADDR_W-1:0] mem_pc_r   [DEPTH];
    logic [EXC_W-1:0]  mem_exc_r  [DEPTH];
    logic              mem_ds_r   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic [PTR_W-1:0]  wr_ptr_nxt_s;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;

    logic              ready_s;
    logic              valid_s;
    logic              push_s;
    logic              pop_s;

    logic [INST_W-1:0] head_inst_s;
    logic [ADDR_W-1:0] head_pc_s;
    logic [EXC_W-1:0]  head_exc_s;
    logic              head_ds_s;

    // Handshake status depends only on the count register, never on _ready,
    // so a full queue refuses a push even when the head is popped that cycle.
    assign ready_s = (count_r != CNT_W'(DEPTH));
    assign valid_s = (count_r != {CNT_W{1'b0}});
    assign push_s  = _valid & ready_s & ~_flush;
    assign pop_s   = valid_s & _ready & ~_flush;

    // Next-state for pointers and occupancy; flush overrides push and pop
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (_flush) begin
            wr_ptr_nxt_s = {PTR_W{1'b0}};
            rd_ptr_nxt_s = {PTR_W{1'b0}};
            count_nxt_s  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer and occupancy registers with asynchronous active-low reset
    always_ff @(posedge _clk or negedge _rst) begin
        if (!_rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Write the accepted entry into the slot at the write pointer
    always_ff @(posedge _clk) begin
        if (push_s) begin
            mem_inst_r[wr_ptr_r] <= _inst;
            mem_pc_r[wr_ptr_r]   <= _pc;
            mem_exc_r[wr_ptr_r]  <= _exc;
            mem_ds_r[wr_ptr_r]   <= _jb_delaysolt;
        end
    end

    // Head entry, forced to a NOP at PC 0 while the queue is empty
    always_comb begin
        head_inst_s = {INST_W{1'b0}};
        head_pc_s   = {ADDR_W{1'b0}};
        head_exc_s  = {EXC_W{1'b0}};
        head_ds_s   = 1'b0;
        if (valid_s) begin
            head_inst_s = mem_inst_r[rd_ptr_r];
            head_pc_s   = mem_pc_r[rd_ptr_r];
            head_exc_s  = mem_exc_r[rd_ptr_r];
            head_ds_s   = mem_ds_r[rd_ptr_r];
        end else begin
            head_inst_s = {INST_W{1'b0}};
            head_pc_s   = {ADDR_W{1'b0}};
            head_exc_s  = {EXC_W{1'b0}};
            head_ds_s   = 1'b0;
        end
    end

    assign ready_        = ready_s;
    assign valid_        = valid_s;
    assign inst_         = head_inst_s;
    assign pc_           = head_pc_s;
    assign exc_          = head_exc_s;
    assign jb_delaysolt_ = head_ds_s;
    // PC views wrap modulo 2^ADDR_W; an empty queue yields 4, 8 and -4
    assign pc_add4_      = head_pc_s + ADDR_W'(4);
    assign pc_add8_      = head_pc_s + ADDR_W'(8);
    assign pc_sub4_      = head_pc_s - ADDR_W'(4);
    assign count_        = count_r;
    assign almost_full_  = (count_r >= CNT_W'(AF_LEVEL));

endmodule

// File: tb/tb_if_id_queue.sv
// Directed testbench for if_id_queue (DEPTH=4, 32-bit PC/instruction).
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_inst = 32'h0;
    logic [31:0] if_pc = 32'h0;
    logic [7:0]  if_exc = 8'h0;
    logic        if_ds = 1'b0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_pc8;
    logic [31:0] id_pcm4;
    logic [7:0]  id_exc;
    logic        id_ds;
    logic [2:0]  count;
    logic        almost_full;

    int n_cmp = 0;
    int n_err = 0;

    if_id_queue #(
        .DEPTH(4), .INST_W(32), .ADDR_W(32), .EXC_W(8), .AF_LEVEL(3)
    ) dut (
        ._clk(clk),
        ._rst(rst_n),
        ._flush(flush),
        ._valid(if_valid),
        .ready_(if_ready),
        ._inst(if_inst),
        ._pc(if_pc),
        ._exc(if_exc),
        ._jb_delaysolt(if_ds),
        .valid_(id_valid),
        ._ready(id_ready),
        .inst_(id_inst),
        .pc_(id_pc),
        .pc_add4_(id_pc4),
        .pc_add8_(id_pc8),
        .pc_sub4_(id_pcm4),
        .exc_(id_exc),
        .jb_delaysolt_(id_ds),
        .count_(count),
        .almost_full_(almost_full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [7:0] exc, input logic ds, input logic rdy);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        if_exc   = exc;
        if_ds    = ds;
        id_ready = rdy;
    endtask

    initial begin
        // Reset state
        #2;
        check_eq("rst_valid", 64'(id_valid), 64'(0));
        check_eq("rst_ready", 64'(if_ready), 64'(1));
        check_eq("rst_count", 64'(count), 64'(0));
        check_eq("rst_inst", 64'(id_inst), 64'(0));
        check_eq("rst_pc4", 64'(id_pc4), 64'h4);
        check_eq("rst_pc8", 64'(id_pc8), 64'h8);
        check_eq("rst_pcm4", 64'(id_pcm4), 64'hFFFF_FFFC);
        check_eq("rst_af", 64'(almost_full), 64'(0));
        step();
        rst_n = 1'b1;
        step();
        check_eq("idle_count", 64'(count), 64'(0));

        // Fill to DEPTH with ID stalled
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hBFC0_0000 + 32'(4 * i), 32'h2408_0001 + 32'(i), 8'h0, 1'b0, 1'b0);
            step();
            if (i == 0) begin
                check_eq("first_valid", 64'(id_valid), 64'(1));
                check_eq("first_pc", 64'(id_pc), 64'hBFC0_0000);
                check_eq("first_inst", 64'(id_inst), 64'h2408_0001);
                check_eq("first_pc8", 64'(id_pc8), 64'hBFC0_0008);
                check_eq("first_pcm4", 64'(id_pcm4), 64'hBFBF_FFFC);
            end
            check_eq("fill_count", 64'(count), 64'(i + 1));
            check_eq("fill_af", 64'(almost_full), 64'((i + 1) >= 3));
            check_eq("fill_ready", 64'(if_ready), 64'((i + 1) != 4));
        end

        // Fifth push while full with a concurrent pop: refused
        drive(1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 8'h0, 1'b0, 1'b1);
        step();
        check_eq("full_pop_count", 64'(count), 64'(3));
        check_eq("full_pop_ready", 64'(if_ready), 64'(1));
        check_eq("full_pop_pc", 64'(id_pc), 64'hBFC0_0004);
        check_eq("full_pop_inst", 64'(id_inst), 64'h2408_0002);
        drive(1'b0, 32'h0, 32'h0, 8'h0, 1'b0, 1'b1);
        step();
        check_eq("drain_pc_a", 64'(id_pc), 64'hBFC0_0008);
        step();
        check_eq("drain_pc_b", 64'(id_pc), 64'hBFC0_000C);
        check_eq("drain_count_b", 64'(count), 64'(1));
        step();
        check_eq("drain_empty_valid", 64'(id_valid), 64'(0));
        check_eq("drain_empty_pc", 64'(id_pc), 64'(0));
        check_eq("drain_empty_count", 64'(count), 64'(0));

        // Push+pop on empty queue: only the push takes effect
        drive(1'b1, 32'h0000_1000, 32'h1, 8'h00, 1'b0, 1'b1);
        step();
        check_eq("empty_pp_count", 64'(count), 64'(1));
        check_eq("empty_pp_pc", 64'(id_pc), 64'h1000);
        drive(1'b1, 32'h0000_1004, 32'h2, 8'h01, 1'b1, 1'b0);
        step();
        check_eq("two_count", 64'(count), 64'(2));

        // Sustained push+pop across pointer wrap; entry j has pc=0x1000+4j, exc=j, ds=j[0]
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 32'h0000_1000 + 32'(4 * (k + 1)), 32'(k + 2), 8'(k + 1),
                  1'((k + 1) % 2), 1'b1);
            step();
            check_eq("pp_count", 64'(count), 64'(2));
            check_eq("pp_pc", 64'(id_pc), 64'(32'h0000_1000 + 32'(4 * k)));
            check_eq("pp_exc", 64'(id_exc), 64'(k));
            check_eq("pp_ds", 64'(id_ds), 64'(k % 2));
        end

        // Fill to 3, then flush with push and pop requested
        drive(1'b1, 32'h0000_1030, 32'hD, 8'h0C, 1'b0, 1'b0);
        step();
        check_eq("pre_flush_count", 64'(count), 64'(3));
        flush = 1'b1;
        drive(1'b1, 32'hAAAA_0000, 32'hAAAA_AAAA, 8'h0, 1'b0, 1'b1);
        step();
        flush = 1'b0;
        check_eq("flush_count", 64'(count), 64'(0));
        check_eq("flush_valid", 64'(id_valid), 64'(0));
        check_eq("flush_ready", 64'(if_ready), 64'(1));
        drive(1'b1, 32'h8000_0180, 32'h4200_0018, 8'h0, 1'b0, 1'b0);
        step();
        check_eq("post_flush_valid", 64'(id_valid), 64'(1));
        check_eq("post_flush_pc", 64'(id_pc), 64'h8000_0180);
        check_eq("post_flush_pc4", 64'(id_pc4), 64'h8000_0184);
        check_eq("post_flush_count", 64'(count), 64'(1));

        // Asynchronous reset mid-cycle with two entries queued
        drive(1'b1, 32'h8000_0184, 32'h0, 8'h0, 1'b0, 1'b0);
        step();
        check_eq("pre_rst_count", 64'(count), 64'(2));
        drive(1'b0, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 64'(id_valid), 64'(0));
        check_eq("arst_count", 64'(count), 64'(0));
        check_eq("arst_ready", 64'(if_ready), 64'(1));
        check_eq("arst_pcm4", 64'(id_pcm4), 64'hFFFF_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
